// File: rtl/ctrl_pipeline_pkg.sv
// rtl/ctrl_pipeline_pkg.sv - shared field positions, widths and forwarding encodings for ctrl_pipeline
//
// Purpose: bit positions inside the WB/M/EX control bundles issued by the decode
// stage, the bundle widths, and the EX operand forwarding select encodings.
// Ports: none (package).
package ctrl_pipeline_pkg;

   localparam int WB_W = 2;
   localparam int M_W  = 3;
   localparam int EX_W = 4;

   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;

   localparam int M_BRANCH   = 2;
   localparam int M_MEMREAD  = 1;
   localparam int M_MEMWRITE = 0;

   localparam int EX_ALUSRC   = 3;
   localparam int EX_ALUOP_HI = 2;
   localparam int EX_ALUOP_LO = 1;
   localparam int EX_REGDST   = 0;

   typedef enum logic [1:0] {
      FWD_REGFILE = 2'b00,
      FWD_MEMWB   = 2'b01,
      FWD_EXMEM   = 2'b10
   } fwd_sel_e;

endpackage

// File: rtl/ctrl_pipeline_fwd_unit.sv
// rtl/ctrl_pipeline_fwd_unit.sv - EX-stage operand forwarding select compare
//
// Purpose: picks the source of both EX operands (register file, EX/MEM result or
// MEM/WB result) by comparing the EX source indices with the destinations of
// the two younger-writing stages.
// Ports:
//   ex_rs, ex_rt   in  REG_W  source indices of the instruction in EX
//   mem_regwrite   in  1      EX/MEM stage will write the register file
//   mem_dst        in  REG_W  EX/MEM destination index
//   wb_regwrite    in  1      MEM/WB stage will write the register file
//   wb_dst         in  REG_W  MEM/WB destination index
//   fwd_a, fwd_b   out 2      operand selects for rs / rt
module fwd_unit
   import ctrl_pipeline_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] ex_rs,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             mem_regwrite,
   input  logic [REG_W-1:0] mem_dst,
   input  logic             wb_regwrite,
   input  logic [REG_W-1:0] wb_dst,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b
);

   // EX/MEM is checked first: it holds the more recent value when both
   // stages target the same register. Register 0 is hardwired, never forwarded.
   function automatic fwd_sel_e sel(input logic [REG_W-1:0] src);
      if (mem_regwrite && (mem_dst != '0) && (mem_dst == src)) begin
         return FWD_EXMEM;
      end else if (wb_regwrite && (wb_dst != '0) && (wb_dst == src)) begin
         return FWD_MEMWB;
      end
      return FWD_REGFILE;
   endfunction

   always_comb begin
      fwd_a = sel(ex_rs);
      fwd_b = sel(ex_rt);
   end

endmodule

// File: rtl/ctrl_pipeline.sv
// rtl/ctrl_pipeline.sv - ID/EX, EX/MEM, MEM/WB control carrier with hazard and forwarding logic
//
// Purpose: registers the decode-stage control bundles through the three
// pipeline boundaries, inserts bubbles on load-use stalls and branch flushes,
// and produces the EX operand forwarding selects.
// Ports:
//   clk, rst                 in   clock, synchronous active-high reset
//   id_valid                 in   ID holds a real instruction
//   id_wb / id_m / id_ex     in   WB / M / EX control bundles from decode
//   id_rs, id_rt, id_rd      in   ID register fields
//   branch_taken             in   MEM-stage branch resolved taken (flush)
//   ex_ex, ex_rs, ex_rt      out  ID/EX controls and source indices
//   ex_dst                   out  ID/EX destination (rd or rt by RegDst)
//   mem_m, mem_dst           out  EX/MEM controls and destination
//   wb_wb, wb_dst            out  MEM/WB controls and destination
//   stall                    out  load-use stall request (combinational)
//   fwd_a, fwd_b             out  EX operand selects (combinational)
module ctrl_pipeline
   import ctrl_pipeline_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [WB_W-1:0]  id_wb,
   input  logic [M_W-1:0]   id_m,
   input  logic [EX_W-1:0]  id_ex,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic [REG_W-1:0] id_rd,
   input  logic             branch_taken,
   output logic [EX_W-1:0]  ex_ex,
   output logic [REG_W-1:0] ex_rs,
   output logic [REG_W-1:0] ex_rt,
   output logic [REG_W-1:0] ex_dst,
   output logic [M_W-1:0]   mem_m,
   output logic [REG_W-1:0] mem_dst,
   output logic [WB_W-1:0]  wb_wb,
   output logic [REG_W-1:0] wb_dst,
   output logic             stall,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b
);

   // ID/EX stage
   logic             idex_valid_q, idex_valid_d;
   logic [WB_W-1:0]  idex_wb_q,    idex_wb_d;
   logic [M_W-1:0]   idex_m_q,     idex_m_d;
   logic [EX_W-1:0]  idex_ex_q,    idex_ex_d;
   logic [REG_W-1:0] idex_rs_q,    idex_rs_d;
   logic [REG_W-1:0] idex_rt_q,    idex_rt_d;
   logic [REG_W-1:0] idex_dst_q,   idex_dst_d;

   // EX/MEM stage
   logic             exmem_valid_q, exmem_valid_d;
   logic [WB_W-1:0]  exmem_wb_q,    exmem_wb_d;
   logic [M_W-1:0]   exmem_m_q,     exmem_m_d;
   logic [REG_W-1:0] exmem_dst_q,   exmem_dst_d;

   // MEM/WB stage
   logic             memwb_valid_q, memwb_valid_d;
   logic [WB_W-1:0]  memwb_wb_q,    memwb_wb_d;
   logic [REG_W-1:0] memwb_dst_q,   memwb_dst_d;

   // A load in EX whose destination is read by the instruction in ID cannot
   // be forwarded in time; hold ID and push a bubble into EX instead.
   always_comb begin
      stall = 1'b0;
      if (id_valid && idex_valid_q && idex_m_q[M_MEMREAD] && (idex_dst_q != '0) &&
          ((idex_dst_q == id_rs) || (idex_dst_q == id_rt))) begin
         stall = 1'b1;
      end
   end

   always_comb begin
      // ID/EX: bubble on empty ID, stall or flush; branch flush wins over stall
      // trivially because both produce the same bubble.
      idex_valid_d = 1'b0;
      idex_wb_d    = '0;
      idex_m_d     = '0;
      idex_ex_d    = '0;
      idex_rs_d    = '0;
      idex_rt_d    = '0;
      idex_dst_d   = '0;
      if (id_valid && !stall && !branch_taken) begin
         idex_valid_d = 1'b1;
         idex_wb_d    = id_wb;
         idex_m_d     = id_m;
         idex_ex_d    = id_ex;
         idex_rs_d    = id_rs;
         idex_rt_d    = id_rt;
         idex_dst_d   = id_ex[EX_REGDST] ? id_rd : id_rt;
      end

      // EX/MEM: the instruction in EX is on the wrong path when a branch
      // resolves taken, so it is squashed as well.
      exmem_valid_d = 1'b0;
      exmem_wb_d    = '0;
      exmem_m_d     = '0;
      exmem_dst_d   = '0;
      if (!branch_taken) begin
         exmem_valid_d = idex_valid_q;
         exmem_wb_d    = idex_wb_q;
         exmem_m_d     = idex_m_q;
         exmem_dst_d   = idex_dst_q;
      end

      // MEM/WB: the branch itself and older instructions always retire.
      memwb_valid_d = exmem_valid_q;
      memwb_wb_d    = exmem_wb_q;
      memwb_dst_d   = exmem_dst_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idex_valid_q  <= 1'b0;
         idex_wb_q     <= '0;
         idex_m_q      <= '0;
         idex_ex_q     <= '0;
         idex_rs_q     <= '0;
         idex_rt_q     <= '0;
         idex_dst_q    <= '0;
         exmem_valid_q <= 1'b0;
         exmem_wb_q    <= '0;
         exmem_m_q     <= '0;
         exmem_dst_q   <= '0;
         memwb_valid_q <= 1'b0;
         memwb_wb_q    <= '0;
         memwb_dst_q   <= '0;
      end else begin
         idex_valid_q  <= idex_valid_d;
         idex_wb_q     <= idex_wb_d;
         idex_m_q      <= idex_m_d;
         idex_ex_q     <= idex_ex_d;
         idex_rs_q     <= idex_rs_d;
         idex_rt_q     <= idex_rt_d;
         idex_dst_q    <= idex_dst_d;
         exmem_valid_q <= exmem_valid_d;
         exmem_wb_q    <= exmem_wb_d;
         exmem_m_q     <= exmem_m_d;
         exmem_dst_q   <= exmem_dst_d;
         memwb_valid_q <= memwb_valid_d;
         memwb_wb_q    <= memwb_wb_d;
         memwb_dst_q   <= memwb_dst_d;
      end
   end

   fwd_unit #(
      .REG_W (REG_W)
   ) u_fwd (
      .ex_rs        (idex_rs_q),
      .ex_rt        (idex_rt_q),
      .mem_regwrite (exmem_valid_q & exmem_wb_q[WB_REGWRITE]),
      .mem_dst      (exmem_dst_q),
      .wb_regwrite  (memwb_valid_q & memwb_wb_q[WB_REGWRITE]),
      .wb_dst       (memwb_dst_q),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b)
   );

   assign ex_ex   = idex_ex_q;
   assign ex_rs   = idex_rs_q;
   assign ex_rt   = idex_rt_q;
   assign ex_dst  = idex_dst_q;
   assign mem_m   = exmem_m_q;
   assign mem_dst = exmem_dst_q;
   assign wb_wb   = memwb_wb_q;
   assign wb_dst  = memwb_dst_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb/tb_ctrl_pipeline.sv - directed self-checking bench for ctrl_pipeline
module tb_ctrl_pipeline;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [1:0] id_wb;
   logic [2:0] id_m;
   logic [3:0] id_ex;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       branch_taken;
   logic [3:0] ex_ex;
   logic [4:0] ex_rs, ex_rt, ex_dst;
   logic [2:0] mem_m;
   logic [4:0] mem_dst;
   logic [1:0] wb_wb;
   logic [4:0] wb_dst;
   logic       stall;
   logic [1:0] fwd_a, fwd_b;

   int vectors = 0;
   int errors  = 0;

   ctrl_pipeline #(.REG_W(5)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_wb        (id_wb),
      .id_m         (id_m),
      .id_ex        (id_ex),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_rd        (id_rd),
      .branch_taken (branch_taken),
      .ex_ex        (ex_ex),
      .ex_rs        (ex_rs),
      .ex_rt        (ex_rt),
      .ex_dst       (ex_dst),
      .mem_m        (mem_m),
      .mem_dst      (mem_dst),
      .wb_wb        (wb_wb),
      .wb_dst       (wb_dst),
      .stall        (stall),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive an ID instruction and let combinational outputs settle.
   task automatic set_id(input logic v, input logic [1:0] wb, input logic [2:0] m,
                         input logic [3:0] ex, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd);
      id_valid = v;
      id_wb    = wb;
      id_m     = m;
      id_ex    = ex;
      id_rs    = rs;
      id_rt    = rt;
      id_rd    = rd;
      #1;
   endtask

   task automatic set_bubble();
      set_id(1'b0, 2'b00, 3'b000, 4'b0000, 5'd0, 5'd0, 5'd0);
   endtask

   initial begin
      // Reset held two cycles with a live lw in ID
      rst = 1'b1;
      branch_taken = 1'b0;
      set_id(1'b1, 2'b11, 3'b010, 4'b1100, 5'd2, 5'd8, 5'd0);
      tick();
      tick();
      chk("rst_ex_ex",   {4'b0, ex_ex},   8'h00);
      chk("rst_ex_dst",  {3'b0, ex_dst},  8'h00);
      chk("rst_mem_m",   {5'b0, mem_m},   8'h00);
      chk("rst_wb_wb",   {6'b0, wb_wb},   8'h00);
      chk("rst_wb_dst",  {3'b0, wb_dst},  8'h00);
      chk("rst_stall",   {7'b0, stall},   8'h00);
      chk("rst_fwd_a",   {6'b0, fwd_a},   8'h00);
      chk("rst_fwd_b",   {6'b0, fwd_b},   8'h00);

      // lw $8 flows through the three stages
      rst = 1'b0;
      tick();
      chk("lw_ex_ex",  {4'b0, ex_ex},  8'h0C);
      chk("lw_ex_dst", {3'b0, ex_dst}, 8'h08);
      chk("lw_ex_rs",  {3'b0, ex_rs},  8'h02);
      set_bubble();
      chk("lw_stall_gated", {7'b0, stall}, 8'h00);
      tick();
      chk("lw_mem_m",   {5'b0, mem_m},   8'h02);
      chk("lw_mem_dst", {3'b0, mem_dst}, 8'h08);
      chk("lw_ex_bub",  {4'b0, ex_ex},   8'h00);
      tick();
      chk("lw_wb_wb",  {6'b0, wb_wb},  8'h03);
      chk("lw_wb_dst", {3'b0, wb_dst}, 8'h08);

      // Load-use: lw $8 in EX, add reading $8 in ID
      set_id(1'b1, 2'b11, 3'b010, 4'b1100, 5'd2, 5'd8, 5'd0);
      tick();
      set_id(1'b1, 2'b10, 3'b000, 4'b0101, 5'd8, 5'd3, 5'd10);
      chk("lu_stall", {7'b0, stall}, 8'h01);
      tick();
      chk("lu_bub_ex_ex",  {4'b0, ex_ex},   8'h00);
      chk("lu_bub_ex_dst", {3'b0, ex_dst},  8'h00);
      chk("lu_mem_m",      {5'b0, mem_m},   8'h02);
      chk("lu_mem_dst",    {3'b0, mem_dst}, 8'h08);
      chk("lu_stall_clr",  {7'b0, stall},   8'h00);
      tick();
      chk("lu_add_ex_ex",  {4'b0, ex_ex},  8'h05);
      chk("lu_add_ex_dst", {3'b0, ex_dst}, 8'h0A);
      chk("lu_wb_dst",     {3'b0, wb_dst}, 8'h08);
      chk("lu_fwd_a_wb",   {6'b0, fwd_a},  8'h01);
      chk("lu_fwd_b_rf",   {6'b0, fwd_b},  8'h00);

      // Writer of $9 in MEM, reader in EX
      set_id(1'b1, 2'b10, 3'b000, 4'b0101, 5'd1, 5'd2, 5'd9);
      tick();
      set_id(1'b1, 2'b10, 3'b000, 4'b0101, 5'd9, 5'd9, 5'd11);
      chk("fw_no_stall", {7'b0, stall}, 8'h00);
      tick();
      chk("fw_mem_a", {6'b0, fwd_a}, 8'h02);
      chk("fw_mem_b", {6'b0, fwd_b}, 8'h02);

      // Writer of $9 in WB, reader (rs=9, rt=4) in EX
      set_id(1'b1, 2'b10, 3'b000, 4'b0101, 5'd1, 5'd2, 5'd9);
      tick();
      set_bubble();
      tick();
      set_id(1'b1, 2'b10, 3'b000, 4'b0101, 5'd9, 5'd4, 5'd11);
      tick();
      chk("fw_wb_a", {6'b0, fwd_a}, 8'h01);
      chk("fw_wb_b", {6'b0, fwd_b}, 8'h00);

      // $9 written in both MEM and WB: EX/MEM wins
      set_id(1'b1, 2'b10, 3'b000, 4'b0101, 5'd1, 5'd2, 5'd9);
      tick();
      tick();
      set_id(1'b1, 2'b10, 3'b000, 4'b0101, 5'd9, 5'd9, 5'd11);
      tick();
      chk("fw_both_a", {6'b0, fwd_a}, 8'h02);
      chk("fw_both_b", {6'b0, fwd_b}, 8'h02);

      // Branch flush with simultaneous load-use stall
      set_id(1'b1, 2'b11, 3'b010, 4'b1100, 5'd1, 5'd5, 5'd0);
      tick();
      set_id(1'b1, 2'b10, 3'b000, 4'b0101, 5'd5, 5'd6, 5'd12);
      branch_taken = 1'b1;
      #1;
      chk("br_stall", {7'b0, stall}, 8'h01);
      tick();
      branch_taken = 1'b0;
      chk("br_ex_ex",   {4'b0, ex_ex},   8'h00);
      chk("br_ex_rs",   {3'b0, ex_rs},   8'h00);
      chk("br_mem_m",   {5'b0, mem_m},   8'h00);
      chk("br_mem_dst", {3'b0, mem_dst}, 8'h00);
      chk("br_wb_wb",   {6'b0, wb_wb},   8'h02);
      chk("br_wb_dst",  {3'b0, wb_dst},  8'h0B);

      // lw to $0 then use of $0: no stall, no forwarding
      set_id(1'b1, 2'b11, 3'b010, 4'b1100, 5'd1, 5'd0, 5'd0);
      tick();
      set_id(1'b1, 2'b10, 3'b000, 4'b0101, 5'd0, 5'd0, 5'd13);
      chk("r0_stall", {7'b0, stall}, 8'h00);
      tick();
      chk("r0_fwd_a", {6'b0, fwd_a}, 8'h00);
      chk("r0_fwd_b", {6'b0, fwd_b}, 8'h00);

      // Mid-stream reset overrides stall and branch
      set_id(1'b1, 2'b11, 3'b010, 4'b1100, 5'd1, 5'd7, 5'd0);
      tick();
      set_id(1'b1, 2'b10, 3'b000, 4'b0101, 5'd7, 5'd7, 5'd14);
      branch_taken = 1'b1;
      rst = 1'b1;
      tick();
      chk("mrst_ex_ex",   {4'b0, ex_ex},   8'h00);
      chk("mrst_mem_m",   {5'b0, mem_m},   8'h00);
      chk("mrst_mem_dst", {3'b0, mem_dst}, 8'h00);
      chk("mrst_wb_wb",   {6'b0, wb_wb},   8'h00);
      chk("mrst_stall",   {7'b0, stall},   8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_pipeline.md
# ctrl_pipeline

Pipeline control carrier for the 5-stage MIPS core: accepts the WB/M/EX control bundles issued by the decode-stage control unit, registers them through the ID/EX, EX/MEM and MEM/WB boundaries, and hands each stage the bits it consumes. It also detects load-use hazards (stall request), applies branch flushes, and produces EX-stage operand forwarding selects. Sits between the control unit/register file in ID and the EX, MEM and WB datapath stages.

## Interface
- REG_W, 5, register index width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_wb  in  2  [1]=RegWrite, [0]=MemToReg
- id_m  in  3  [2]=Branch, [1]=MemRead, [0]=MemWrite
- id_ex  in  4  [3]=ALUSrc, [2:1]=ALUOp, [0]=RegDst
- id_rs, id_rt, id_rd  in  REG_W each  source/destination fields of the ID instruction
- branch_taken  in  1  MEM-stage branch resolved taken
- ex_ex  out  4  EX controls (ID/EX register)
- ex_rs, ex_rt  out  REG_W  registered source indices
- ex_dst  out  REG_W  selected destination: id_rd if RegDst=1 else id_rt, registered
- mem_m  out  3  MEM controls (EX/MEM register)
- mem_dst  out  REG_W
- wb_wb  out  2  WB controls (MEM/WB register)
- wb_dst  out  REG_W
- stall  out  1  load-use stall request to PC/IF-ID (combinational)
- fwd_a, fwd_b  out  2  EX operand selects: 00 regfile, 10 from EX/MEM, 01 from MEM/WB (combinational)

## Operation
- Three register stages: ID/EX holds {valid, wb, m, ex, rs, rt, dst}; EX/MEM holds {valid, wb, m, dst}; MEM/WB holds {valid, wb, dst}. Each stage drops the bundle its stage consumes.
- Bubble = valid 0 and all control bits 0; index fields 0.
- Bundle with id_valid=0 loads as a bubble.
- stall = ID/EX valid & ex_m[1] (MemRead) & ex_dst≠0 & (ex_dst==id_rs | ex_dst==id_rt), gated by id_valid.
- On stall: ID/EX loads a bubble; EX/MEM and MEM/WB advance normally.
- On branch_taken: ID/EX and EX/MEM load bubbles; MEM/WB advances normally. branch_taken dominates stall.
- fwd_a: 10 if EX/MEM RegWrite & mem_dst≠0 & mem_dst==ex_rs; else 01 if MEM/WB RegWrite & wb_dst≠0 & wb_dst==ex_rs; else 00. fwd_b same against ex_rt. EX/MEM wins when both match.
- Register 0 never triggers stall or forwarding.

## Timing
- Reset: every stage register cleared to bubble; all registered outputs 0; stall and fwd_* evaluate to 0 after reset.
- Latency: ID→EX 1 cycle, →MEM 2 cycles, →WB 3 cycles.
- rst asserted mid-stream clears all stages on the next edge regardless of stall/branch_taken.
- stall, fwd_a, fwd_b are combinational from current stage registers and ID inputs; no registered delay.
- Stall held across consecutive cycles keeps inserting bubbles; it deasserts the cycle after the load leaves ID/EX.

## Structure
- Shared package: bit-position constants for WB/M/EX fields (WB_REGWRITE=1, WB_MEMTOREG=0, M_BRANCH=2, M_MEMREAD=1, M_MEMWRITE=0, EX_ALUSRC=3, EX_ALUOP=2:1, EX_REGDST=0), bundle widths, forwarding select encodings.
- One natural sub-module: fwd_unit (combinational forwarding compare, instantiated once, both operands).

## Test plan
- Reset: hold rst 2 cycles with id_valid=1, lw controls -> all outputs 0, stall=0, fwd=00.
- lw flow: id_wb=11, id_m=010, id_ex=1100, rt=8 -> ex_ex=1100/ex_dst=8 at +1, mem_m=010 at +2, wb_wb=11/wb_dst=8 at +3.
- Load-use: lw writing $8 in EX, ID add with rs=8 -> stall=1, next ID/EX is bubble, lw continues to MEM.
- Forwarding: add writing $9 in MEM, add in EX with rs=9, rt=9 -> fwd_a=fwd_b=10; same with writer in WB -> 01; both stages writing $9 -> 10.
- Branch flush with simultaneous stall: branch_taken=1 -> ID/EX and EX/MEM bubbles next cycle, MEM/WB receives prior EX/MEM.
- $0 destination: lw to $0 followed by use of $0 -> stall=0, fwd=00.
